imem_boot_arbiter: RTL and testbench
====================================

Name: imem_boot_arbiter

Overview:
Owns the single instruction-memory port. After reset it sequences a boot load of program words from a loader stream while holding the core. It then releases the core and arbitrates the port between pipeline fetch reads and runtime patch writes. Sits between the fetch stage, the loader/debug interface and the instruction memory array (combinational read, synchronous write).

Parameters:
DEPTH, 1024, number of 32-bit words in instruction memory
ADDR_W, 10, word-address width, equal to log2(DEPTH)
NOP_WORD, 32'h00000013, word returned for out-of-range fetches (addi x0,x0,0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ld_valid  in  1  loader word valid
ld_ready  out  1  arbiter accepts loader word
ld_data  in  32  loader word
ld_last  in  1  marks final boot word
patch_valid  in  1  runtime write request
patch_ready  out  1  patch write accepted this cycle
patch_addr  in  ADDR_W  patch word address
patch_data  in  32  patch word
fetch_req  in  1  fetch read request
fetch_addr  in  32  fetch byte address; bits [1:0] ignored
fetch_gnt  out  1  fetch served this cycle
fetch_rdata  out  32  instruction to fetch stage
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory combinational read data
cpu_hold  out  1  holds core in reset/stall until boot completes
load_done  out  1  boot load complete (sticky until rst)
word_count  out  ADDR_W+1  number of boot words written

Behaviour:
- States: IDLE, LOAD, RUN, ERR. ERR is reachable only with the optional feature.
- Reset (rst=1 at a clk edge): state=IDLE, wr_ptr=0, word_count=0, load_done=0, cpu_hold=1, patch-priority flag=0. Memory contents are not cleared.
- Combinational outputs while rst is high: ld_ready=0, patch_ready=0, fetch_gnt=0, mem_we=0, fetch_rdata=0.
- IDLE: lasts one cycle; always goes to LOAD. All handshakes are low.
- LOAD: ld_ready=1. A transfer is ld_valid&ld_ready.
  - On a transfer, in the same cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=ld_data.
  - At the edge: wr_ptr+1, word_count+1.
  - Go to RUN after a transfer with ld_last=1, or after the transfer at wr_ptr=DEPTH-1 (memory full; later loader words are refused).
  - In LOAD: fetch_gnt=0, fetch_rdata=0, patch_ready=0.
- RUN:
  - cpu_hold=0 and load_done=1 from the first RUN cycle. Both are registered, so they change the cycle after the last transfer.
  - ld_ready=0.
  - Arbitration, one access per cycle:
    - patch_valid and not prio_fetch: patch_ready=1, mem_we=1, mem_addr=patch_addr, mem_wdata=patch_data, fetch_gnt=0.
    - Otherwise fetch_req: fetch_gnt=1, mem_addr=fetch_addr[ADDR_W+1:2].
  - prio_fetch is set at the edge after a granted patch if fetch_req was also high. It clears after the next fetch grant. Consequence: patches and fetches alternate under contention, and no more than one consecutive patch is granted while a fetch is waiting.
- fetch_rdata:
  - mem_rdata when fetch_gnt=1 and fetch_addr[31:2] < DEPTH.
  - NOP_WORD when fetch_gnt=1 and the address is out of range.
  - 0 when fetch_gnt=0.
- Write/read collision: a fetch is never granted in the same cycle as a write, so there is no read-during-write.
- Reset mid-LOAD or mid-RUN returns to IDLE and restarts the boot.
- word_count saturates at DEPTH.
- mem_addr=0 and mem_wdata=0 whenever there is no access.

Optional Feature:
IMEM_CKSUM_EN:
- Defined: LOAD keeps a 32-bit running sum of accepted data words (wraps mod 2^32). The word after the ld_last transfer is the expected checksum.
  - It is accepted with ld_ready=1 but not written to memory (mem_we=0).
  - Match: go to RUN.
  - Mismatch: go to ERR. ERR keeps cpu_hold=1, load_done=0 and all handshakes low; only rst exits ERR.
  - If the memory-full condition occurs, the checksum word is still expected.
- Undefined: no sum logic, no checksum word, ERR does not exist.

Test Plan:
- Boot: rst, then load 0x00A00093, 0x00A00113, 0x00100193 with ld_last on the third -> mem_we pulses at addresses 0,1,2; word_count=3; cpu_hold falls the next cycle; load_done=1.
- Fetch after boot: fetch_req with fetch_addr=0x8 -> fetch_gnt=1, fetch_rdata=0x00100193. fetch_addr=0x1000 (DEPTH=1024) -> fetch_rdata=0x00000013.
- Contention: patch_valid and fetch_req held high for 4 cycles -> grants alternate patch, fetch, patch, fetch; the patch at addr 5 is read back by a fetch at 0x14.
- Full: stream DEPTH words without ld_last -> transition to RUN after word 1023; ld_ready=0 afterwards; word_count=1024.
- Reset mid-load: rst asserted after 2 of 5 words -> next cycle state=IDLE, word_count=0; reload works from address 0.
- IMEM_CKSUM_EN: words 1,2,3 with last, then checksum 6 -> RUN. Same words with checksum 7 -> ERR, cpu_hold stays 1 until rst.

Source files
------------

// File: rtl/imem_boot_arbiter.sv
// Instruction-memory port owner: boot load from a loader stream, then fetch/patch arbitration.
// Optional IMEM_CKSUM_EN adds a trailing checksum word to the boot stream and an ERR state.
module imem_boot_arbiter #(
    parameter int          DEPTH    = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              patch_valid,
    output logic              patch_ready,
    input  logic [ADDR_W-1:0] patch_addr,
    input  logic [31:0]       patch_data,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic [31:0]       fetch_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        fsm_state
);

    // Handshakes: a loader word moves on ld_valid & ld_ready, a patch is
    // written on patch_valid & patch_ready, a fetch is served when fetch_gnt
    // is high; all readies/grants are combinational and low during rst.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   word_count_q;
    logic              load_done_q;
    logic              cpu_hold_q;
    logic              prio_fetch_q;

    logic ld_xfer;
    logic word_wr;
    logic boot_end;
    logic patch_go;
    logic fetch_go;
    logic in_range;

`ifdef IMEM_CKSUM_EN
    logic [31:0] sum_q;
    logic        ck_phase_q;
`endif

    // Byte offset within a word has no meaning for a word-wide memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign in_range = (fetch_addr[31:2] < 30'(DEPTH));

    always_comb begin
        state_d     = state_q;
        ld_ready    = 1'b0;
        patch_ready = 1'b0;
        fetch_gnt   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        ld_xfer     = 1'b0;
        word_wr     = 1'b0;
        boot_end    = 1'b0;
        patch_go    = 1'b0;
        fetch_go    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: state_d = LOAD;
                LOAD: begin
                    ld_ready = 1'b1;
                    ld_xfer  = ld_valid;
`ifdef IMEM_CKSUM_EN
                    // The word after the last data word is the checksum, never stored.
                    if (ck_phase_q) begin
                        if (ld_xfer) state_d = (ld_data == sum_q) ? RUN : ERR;
                    end else begin
                        word_wr = ld_xfer;
                    end
`else
                    word_wr = ld_xfer;
`endif
                    boot_end = word_wr && (ld_last || (wr_ptr_q == LAST_ADDR));
                    if (word_wr) begin
                        mem_we    = 1'b1;
                        mem_addr  = wr_ptr_q;
                        mem_wdata = ld_data;
                    end
`ifndef IMEM_CKSUM_EN
                    if (boot_end) state_d = RUN;
`endif
                end
                RUN: begin
                    patch_go = patch_valid && !prio_fetch_q;
                    fetch_go = !patch_go && fetch_req;
                    if (patch_go) begin
                        patch_ready = 1'b1;
                        mem_we      = 1'b1;
                        mem_addr    = patch_addr;
                        mem_wdata   = patch_data;
                    end else if (fetch_go) begin
                        fetch_gnt = 1'b1;
                        mem_addr  = fetch_addr[ADDR_W+1:2];
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_rdata = '0;
        if (fetch_gnt) fetch_rdata = in_range ? mem_rdata : NOP_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            cpu_hold_q   <= 1'b1;
            prio_fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (word_wr) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (word_count_q < FULL_CNT) word_count_q <= word_count_q + (ADDR_W + 1)'(1);
            end
            // Registered so the core sees the release on the first RUN cycle.
            load_done_q <= (state_d == RUN);
            cpu_hold_q  <= (state_d != RUN);
            if (patch_go && fetch_req) prio_fetch_q <= 1'b1;
            else if (fetch_go)         prio_fetch_q <= 1'b0;
        end
    end

`ifdef IMEM_CKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q      <= '0;
            ck_phase_q <= 1'b0;
        end else begin
            if (state_q == IDLE) sum_q <= '0;
            else if (word_wr)    sum_q <= sum_q + ld_data;
            ck_phase_q <= (state_d == LOAD) && (ck_phase_q || boot_end);
        end
    end
`endif

    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter: boot, fetch/patch arbitration vectors, reset and full-load corners.
module tb_imem_boot_arbiter;

  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_ERR = 2'd3;

  logic clk;
  logic rst;
  logic ld_valid, ld_ready, ld_last;
  logic [31:0] ld_data;
  logic patch_valid, patch_ready;
  logic [ADDR_W-1:0] patch_addr;
  logic [31:0] patch_data;
  logic fetch_req, fetch_gnt;
  logic [31:0] fetch_addr, fetch_rdata;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic cpu_hold, load_done;
  logic [ADDR_W:0] word_count;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] boot_words[0:7];
  logic [31:0] mem[0:DEPTH-1];

  imem_boot_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_addr(patch_addr), .patch_data(patch_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_rdata(fetch_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count), .fsm_state(fsm_state)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // scoreboard: every memory write must match the next expected {addr, data}
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL mem_write_unexpected: got addr 0x%03h data 0x%08h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_errors++;
          $display("FAIL mem_write: got addr 0x%03h data 0x%08h, required addr 0x%03h data 0x%08h",
                   mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_last = 0; ld_data = 0;
    patch_valid = 0; patch_addr = 0; patch_data = 0;
    fetch_req = 0; fetch_addr = 0;
  endtask

  // one reset cycle, then step through IDLE into LOAD
  task automatic reset_to_load();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    #3;
    check("idle_state", 32'(fsm_state), 32'(ST_IDLE));
    check("idle_ld_ready", 32'(ld_ready), 32'd0);
    next_cycle();
    check("load_state", 32'(fsm_state), 32'(ST_LOAD));
  endtask

`ifdef IMEM_CKSUM_EN
  task automatic send_cksum(input logic [31:0] value);
    ld_valid = 1; ld_last = 0; ld_data = value;
    #3;
    check("cksum_ld_ready", 32'(ld_ready), 32'd1);
    check("cksum_no_write", 32'(mem_we), 32'd0);
    next_cycle();
    ld_valid = 0;
  endtask
`endif

  task automatic boot_seq(input int n, input bit with_last);
`ifdef IMEM_CKSUM_EN
    logic [31:0] sum;
    sum = 0;
`endif
    for (int i = 0; i < n; i++) begin
      ld_valid = 1;
      ld_data = boot_words[i];
      ld_last = with_last && (i == n - 1);
      exp_q.push_back({ADDR_W'(i), boot_words[i]});
`ifdef IMEM_CKSUM_EN
      sum = sum + boot_words[i];
`endif
      #3;
      check($sformatf("boot_ld_ready_%0d", i), 32'(ld_ready), 32'd1);
      check($sformatf("boot_mem_addr_%0d", i), 32'(mem_addr), i);
      next_cycle();
    end
    ld_valid = 0;
    ld_last = 0;
`ifdef IMEM_CKSUM_EN
    if (with_last) send_cksum(sum);
`endif
  endtask

  typedef struct {
    logic fr;
    logic [31:0] fa;
    logic pv;
    logic [ADDR_W-1:0] pa;
    logic [31:0] pd;
    logic gnt;
    logic pr;
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int bad_ready;
    // fr fa pv pa pd | gnt pr we addr rd
    vecs[0]  = '{1, 32'h8, 0, 0, 0, 1, 0, 0, 10'd2, 32'h00100193};
    vecs[1]  = '{1, 32'h1000, 0, 0, 0, 1, 0, 0, 10'd0, 32'h00000013};
    vecs[2]  = '{1, 32'h0, 0, 0, 0, 1, 0, 0, 10'd0, 32'h00A00093};
    vecs[3]  = '{1, 32'h6, 0, 0, 0, 1, 0, 0, 10'd1, 32'h00A00113};
    vecs[4]  = '{0, 32'h8, 0, 0, 0, 0, 0, 0, 10'd0, 32'h0};
    vecs[5]  = '{0, 32'h0, 1, 10'd7, 32'h11111111, 0, 1, 1, 10'd7, 32'h0};
    vecs[6]  = '{1, 32'h1C, 0, 0, 0, 1, 0, 0, 10'd7, 32'h11111111};
    vecs[7]  = '{1, 32'h14, 1, 10'd5, 32'hCAFEF00D, 0, 1, 1, 10'd5, 32'h0};
    vecs[8]  = '{1, 32'h14, 1, 10'd5, 32'h12345678, 1, 0, 0, 10'd5, 32'hCAFEF00D};
    vecs[9]  = '{1, 32'h14, 1, 10'd5, 32'h12345678, 0, 1, 1, 10'd5, 32'h0};
    vecs[10] = '{1, 32'h14, 1, 10'd5, 32'h0BADBEEF, 1, 0, 0, 10'd5, 32'h12345678};
    vecs[11] = '{1, 32'hFFFFFFFC, 0, 0, 0, 1, 0, 0, 10'h3FF, 32'h00000013};
    vecs[12] = '{0, 32'h0, 1, 10'h3FF, 32'hA5A5A5A5, 0, 1, 1, 10'h3FF, 32'h0};
    vecs[13] = '{1, 32'hFFC, 0, 0, 0, 1, 0, 0, 10'h3FF, 32'hA5A5A5A5};

    // reset: combinational outputs forced low, registers at reset values
    idle_inputs();
    rst = 1;
    next_cycle();
    ld_valid = 1; patch_valid = 1; fetch_req = 1; fetch_addr = 0;
    #3;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_patch_ready", 32'(patch_ready), 32'd0);
    check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_fetch_rdata", fetch_rdata, 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    next_cycle();

    // boot three words
    reset_to_load();
    check("load_cpu_hold", 32'(cpu_hold), 32'd1);
    boot_words[0] = 32'h00A00093;
    boot_words[1] = 32'h00A00113;
    boot_words[2] = 32'h00100193;
    boot_seq(3, 1);
    check("boot_state_run", 32'(fsm_state), 32'(ST_RUN));
    check("boot_word_count", 32'(word_count), 32'd3);
    check("boot_cpu_hold", 32'(cpu_hold), 32'd0);
    check("boot_load_done", 32'(load_done), 32'd1);
    ld_valid = 1;
    #3;
    check("run_ld_ready", 32'(ld_ready), 32'd0);
    next_cycle();
    ld_valid = 0;

    // arbitration vectors
    for (int i = 0; i < 14; i++) begin
      fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa;
      patch_valid = vecs[i].pv; patch_addr = vecs[i].pa; patch_data = vecs[i].pd;
      if (vecs[i].we) exp_q.push_back({vecs[i].addr, vecs[i].pd});
      #3;
      check($sformatf("vec%0d_fetch_gnt", i), 32'(fetch_gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_patch_ready", i), 32'(patch_ready), 32'(vecs[i].pr));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_fetch_rdata", i), fetch_rdata, vecs[i].rd);
      next_cycle();
    end
    idle_inputs();

    // reset from RUN clears the boot status
    rst = 1;
    next_cycle();
    rst = 0;
    check("rerun_load_done", 32'(load_done), 32'd0);
    check("rerun_cpu_hold", 32'(cpu_hold), 32'd1);
    next_cycle();

    // reset mid-load after 2 of 5 words, then reload from address 0
    for (int i = 0; i < 5; i++) boot_words[i] = 32'h7700_0000 + i;
    boot_seq(2, 0);
    check("midload_word_count", 32'(word_count), 32'd2);
    rst = 1; ld_valid = 1;
    #3;
    check("midload_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("midload_rst_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    rst = 0; ld_valid = 0;
    check("midload_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("midload_word_count0", 32'(word_count), 32'd0);
    next_cycle();
    boot_words[0] = 32'h0000_1111;
    boot_words[1] = 32'h0000_2222;
    boot_words[2] = 32'h0000_3333;
    boot_seq(3, 1);
    check("reload_word_count", 32'(word_count), 32'd3);
    check("reload_state_run", 32'(fsm_state), 32'(ST_RUN));
    fetch_req = 1; fetch_addr = 32'h0;
    #3;
    check("reload_fetch0", fetch_rdata, 32'h0000_1111);
    next_cycle();
    idle_inputs();

    // full memory without ld_last
    reset_to_load();
    bad_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_last = 0; ld_data = 32'hF000_0000 | i;
      exp_q.push_back({ADDR_W'(i), 32'hF000_0000 | i});
      #3;
      if (ld_ready !== 1'b1) bad_ready++;
      next_cycle();
    end
    ld_valid = 0;
    check("full_ld_ready_count", bad_ready, 0);
    check("full_word_count", 32'(word_count), 32'(DEPTH));
`ifdef IMEM_CKSUM_EN
    check("full_wait_cksum", 32'(fsm_state), 32'(ST_LOAD));
    send_cksum(32'(DEPTH) * 32'hF000_0000 + 32'((DEPTH * (DEPTH - 1)) / 2));
`endif
    check("full_state_run", 32'(fsm_state), 32'(ST_RUN));
    ld_valid = 1; ld_data = 32'hDEAD_BEEF;
    #3;
    check("full_ld_refused", 32'(ld_ready), 32'd0);
    check("full_no_write", 32'(mem_we), 32'd0);
    next_cycle();
    ld_valid = 0; fetch_req = 1; fetch_addr = 32'hFFC;
    #3;
    check("full_fetch_last", fetch_rdata, 32'hF000_03FF);
    next_cycle();
    idle_inputs();

`ifdef IMEM_CKSUM_EN
    // checksum match and mismatch
    reset_to_load();
    boot_words[0] = 32'd1; boot_words[1] = 32'd2; boot_words[2] = 32'd3;
    boot_seq(3, 1);
    check("ck_match_run", 32'(fsm_state), 32'(ST_RUN));
    reset_to_load();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = boot_words[i]; ld_last = (i == 2);
      exp_q.push_back({ADDR_W'(i), boot_words[i]});
      next_cycle();
    end
    send_cksum(32'd7);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; fetch_req = 1; patch_valid = 1;
      #3;
      check("ck_err_state", 32'(fsm_state), 32'(ST_ERR));
      check("ck_err_cpu_hold", 32'(cpu_hold), 32'd1);
      check("ck_err_load_done", 32'(load_done), 32'd0);
      check("ck_err_handshakes", {29'd0, ld_ready, patch_ready, fetch_gnt}, 32'd0);
      next_cycle();
    end
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
    check("ck_err_exit_idle", 32'(fsm_state), 32'(ST_IDLE));
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
